// File: rtl/lamp_pacer.sv
// lamp_pacer: debounces the run/stop and speed/step keys, keeps the
// STOP/RUN state and produces the one-cycle step pulse for the lamp driver.
module lamp_pacer #(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned DEB_W      = 20,
  parameter int unsigned BASE_DIV   = 25000000,
  parameter int unsigned CNT_W      = 26
) (
  input  logic       clk,
  input  logic       rset,
  input  logic       key_run,
  input  logic       key_speed,
  output logic       step,
  output logic       running,
  output logic [1:0] speed
);

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] BASE     = CNT_W'(BASE_DIV);

  // Bit 0 carries the run key, bit 1 the speed key.
  logic [1:0]       keys;
  logic [1:0]       sync1, sync2;
  logic [1:0]       deb, deb_d;
  logic [1:0]       press;
  logic [DEB_W-1:0] deb_cnt [2];

  state_t           state, state_nx;
  logic [1:0]       speed_nx;
  logic [CNT_W-1:0] pcnt, pcnt_nx;
  logic [CNT_W-1:0] period;
  logic             term;
  logic             step_nx;
  logic             run_p, spd_p;

  assign keys  = {key_speed, key_run};
  assign run_p = press[0];
  assign spd_p = press[1];

  // Synchronise, debounce and edge-detect both keys; press marks a debounced fall.
  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      deb_d <= '1;
      press <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb_d & ~deb;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // FSM, speed, prescaler and step registers.
  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      state <= STOP;
      speed <= '0;
      pcnt  <= '0;
      step  <= 1'b0;
    end else begin
      state <= state_nx;
      speed <= speed_nx;
      pcnt  <= pcnt_nx;
      step  <= step_nx;
    end
  end

  // Next-state logic: run press beats speed press; a speed press on the
  // terminal count still lets that step through before the prescaler clears.
  always_comb begin
    state_nx = state;
    speed_nx = speed;
    pcnt_nx  = pcnt;
    step_nx  = 1'b0;
    period   = BASE >> speed;
    term     = (pcnt == period - 1'b1);
    case (state)
      STOP: begin
        pcnt_nx = '0;
        if (run_p) begin
          state_nx = RUN;
        end else if (spd_p) begin
          step_nx = 1'b1;
        end
      end
      RUN: begin
        if (run_p) begin
          state_nx = STOP;
          pcnt_nx  = '0;
        end else begin
          step_nx = term;
          pcnt_nx = term ? '0 : pcnt + 1'b1;
          if (spd_p) begin
            speed_nx = speed + 1'b1;
            pcnt_nx  = '0;
          end
        end
      end
      default: state_nx = STOP;
    endcase
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_lamp_pacer.sv
// Bench for lamp_pacer: stimulus tasks push predicted step edges and state
// changes into queues; a monitor pops and compares whenever outputs move.
module tb_lamp_pacer;

  localparam int DEB  = 4;
  localparam int BASE = 16;

  logic       clk = 1'b0;
  logic       rset;
  logic       key_run;
  logic       key_speed;
  logic       step;
  logic       running;
  logic [1:0] speed;

  lamp_pacer #(
    .DEB_CYCLES(DEB),
    .DEB_W(3),
    .BASE_DIV(BASE),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rset(rset),
    .key_run(key_run),
    .key_speed(key_speed),
    .step(step),
    .running(running),
    .speed(speed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int e;
    int r;
    int s;
  } st_t;

  int  edge_n  = 0;
  int  n_chk   = 0;
  int  n_pass  = 0;
  int  n_steps = 0;
  int  step_q[$];
  st_t st_q[$];

  // Reference model: run flag, speed level, edge of last prescaler clear.
  int m_run, m_spd, m_clr, gen_upto;

  function automatic int per(int s);
    return BASE >> s;
  endfunction

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
  endtask

  // Auto steps land every PERIOD edges after the last clear while running.
  task automatic gen_to(int upto);
    for (int n = gen_upto + 1; n <= upto; n++)
      if (m_run != 0 && (n - m_clr) % per(m_spd) == 0) step_q.push_back(n);
    if (upto > gen_upto) gen_upto = upto;
  endtask

  task automatic run_cycles(int n);
    gen_to(edge_n + n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_event(int ee, bit kr, bit ks);
    gen_to(ee - 1);
    if (kr) begin
      if (m_run != 0) m_run = 0;
      else begin
        m_run = 1;
        m_clr = ee;
      end
      st_q.push_back('{ee, m_run, m_spd});
    end else if (ks) begin
      if (m_run != 0) begin
        if ((ee - m_clr) % per(m_spd) == 0) step_q.push_back(ee);
        m_spd = (m_spd + 1) % 4;
        m_clr = ee;
        st_q.push_back('{ee, m_run, m_spd});
      end else begin
        step_q.push_back(ee);
      end
    end
    gen_upto = ee;
  endtask

  // Clean press: first low sample at edge_n+1, FSM acts DEB+3 edges later.
  task automatic press(bit kr, bit ks, int hold, int idle);
    apply_event(edge_n + DEB + 4, kr, ks);
    if (kr) key_run = 1'b0;
    if (ks) key_speed = 1'b0;
    run_cycles(hold);
    key_run   = 1'b1;
    key_speed = 1'b1;
    run_cycles(DEB + 3 + idle);
  endtask

  task automatic glitch(bit on_run, int len, int idle);
    if (on_run) key_run = 1'b0;
    else key_speed = 1'b0;
    run_cycles(len);
    key_run   = 1'b1;
    key_speed = 1'b1;
    run_cycles(DEB + 3 + idle);
  endtask

  // Wait until a run press would land exactly on a terminal count.
  task automatic press_run_at_terminal(int idle);
    if (m_run == 0) press(1'b1, 1'b0, DEB, 2);
    while (((edge_n + DEB + 4) - m_clr) % per(m_spd) != 0) run_cycles(1);
    press(1'b1, 1'b0, DEB, idle);
  endtask

  task automatic random_ops(int count);
    for (int k = 0; k < count; k++) begin
      int r;
      int hold;
      int idle;
      r    = int'($urandom_range(0, 9));
      hold = int'($urandom_range(DEB, DEB + 8));
      idle = int'($urandom_range(0, 30));
      if (r <= 1) glitch(r[0], int'($urandom_range(1, DEB - 1)), idle);
      else if (r == 2 && m_run != 0) press_run_at_terminal(idle);
      else if (r <= 4) press(1'b1, 1'b0, hold, idle);
      else if (r <= 8) press(1'b0, 1'b1, hold, idle);
      else press(1'b1, 1'b1, hold, idle);
    end
  endtask

  // Monitor: pops the scoreboard on every step pulse and state change.
  initial begin : monitor
    logic [2:0] prev;
    st_t        x;
    prev = '0;
    forever begin
      @(posedge clk);
      edge_n++;
      #1;
      if (!rset) begin
        prev = '0;
      end else begin
        if (step) begin
          n_steps++;
          if (step_q.size() == 0) begin
            n_chk++;
            $display("FAIL step_edge: pulse at edge %0d, none expected", edge_n);
          end else begin
            check("step_edge", edge_n, step_q.pop_front());
          end
        end
        if ({running, speed} != prev) begin
          if (st_q.size() == 0) begin
            n_chk++;
            $display("FAIL state: running=%0d speed=%0d at edge %0d, no change expected",
                     running, speed, edge_n);
          end else begin
            x = st_q.pop_front();
            check("state_edge", edge_n, x.e);
            check("running", int'(running), x.r);
            check("speed", int'(speed), x.s);
          end
          prev = {running, speed};
        end
      end
    end
  end

  initial begin : stim
    int s0;
    rset      = 1'b0;
    key_run   = 1'b0;
    key_speed = 1'b0;
    m_run = 0; m_spd = 0; m_clr = 0; gen_upto = 0;
    repeat (3) @(negedge clk);
    check("reset_step", int'(step), 0);
    check("reset_running", int'(running), 0);
    check("reset_speed", int'(speed), 0);
    key_run   = 1'b1;
    key_speed = 1'b1;
    @(negedge clk);
    gen_upto = edge_n;
    rset     = 1'b1;
    run_cycles(100);

    glitch(1'b1, 3, 5);
    check("glitch_running", int'(running), 0);
    press(1'b1, 1'b0, 20, 5);
    check("run_after_press", int'(running), 1);

    s0 = n_steps;
    run_cycles(80);
    check("steps_in_80", n_steps - s0, 5);
    repeat (3) press(1'b0, 1'b1, DEB, 2);
    check("speed_3", int'(speed), 3);
    s0 = n_steps;
    run_cycles(20);
    check("steps_in_20_fast", n_steps - s0, 10);
    press(1'b0, 1'b1, DEB + 2, 4);
    check("speed_wrap", int'(speed), 0);

    press(1'b1, 1'b0, DEB, 4);
    s0 = n_steps;
    repeat (3) press(1'b0, 1'b1, DEB + 1, 6);
    check("manual_steps", n_steps - s0, 3);
    check("manual_speed", int'(speed), 0);

    press(1'b1, 1'b1, DEB + 2, 3);
    check("both_running", int'(running), 1);
    check("both_speed", int'(speed), 0);

    press_run_at_terminal(10);
    check("term_stop_running", int'(running), 0);

    random_ops(40);

    if (m_run == 0) press(1'b1, 1'b0, DEB, 2);
    while (m_spd != 2) press(1'b0, 1'b1, DEB, 2);
    key_run = 1'b0;
    run_cycles(2);
    rset = 1'b0;
    #1;
    check("midreset_step", int'(step), 0);
    check("midreset_running", int'(running), 0);
    check("midreset_speed", int'(speed), 0);
    m_run = 0; m_spd = 0; m_clr = 0;
    key_run = 1'b1;
    repeat (3) @(negedge clk);
    gen_upto = edge_n;
    rset     = 1'b1;
    run_cycles(40);
    check("post_reset_running", int'(running), 0);

    random_ops(8);
    run_cycles(5);
    check("steps_left", step_q.size(), 0);
    check("states_left", st_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lamp_pacer.md
# lamp_pacer

Pacing stage that sits directly upstream of the running-light lamp driver. It debounces two raw push buttons, run/stop and speed/step, and keeps a run/stop state machine. From a programmable prescaler it generates the one-cycle `step` pulse that advances the chaser by one position. The driver consumes `step` as its count enable.

## Interface
Parameters:
- `DEB_CYCLES`, default 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz).
- `DEB_W`, default 20: debounce counter width; must hold `DEB_CYCLES-1`.
- `BASE_DIV`, default 25000000: step period in clocks at speed 0; must be ≥ 8.
- `CNT_W`, default 26: prescaler width; must hold `BASE_DIV-1`.

Ports:
- `clk`, input, 1: single clock; all state on its rising edge.
- `rset`, input, 1: reset, asynchronous, active-low.
- `key_run`, input, 1: raw run/stop button, active-low, asynchronous to `clk`.
- `key_speed`, input, 1: raw speed/step button, active-low, asynchronous to `clk`.
- `step`, output, 1: one-cycle advance pulse to the lamp driver.
- `running`, output, 1: 1 in RUN, 0 in STOP.
- `speed`, output, 2: current speed level, 0 to 3.

## Operation
- **Reset values** (any time `rset`=0, immediately): `step`=0, `running`=0 (STOP), `speed`=0, prescaler=0, debounce counters=0, sync flops=1, debounced levels=1 (released), press pulses=0.
- **Key path**, one per key:
  - 2-flop synchronizer feeds the debouncer.
  - The debounce counter clears whenever the synced level equals the debounced level. Otherwise it increments.
  - When the counter equals `DEB_CYCLES-1` and the levels still differ, the debounced level takes the synced value and the counter clears.
  - A registered one-cycle `press` fires on each debounced 1→0 transition. Releases produce no event.
- **FSM states:** STOP, RUN.
  - STOP + run press → RUN. Prescaler clears to 0.
  - RUN + run press → STOP. Prescaler clears to 0; no further auto steps.
  - STOP + speed press → one manual `step` pulse. Speed is unchanged.
  - RUN + speed press → `speed` advances 0→1→2→3→0, wrapping at 3. Prescaler clears to 0.
  - If both presses occur in the same cycle, the run press wins and the speed press is discarded.
- **Prescaler** (RUN only):
  - `PERIOD = BASE_DIV >> speed`, giving periods BASE_DIV, /2, /4, /8.
  - The counter runs 0 to `PERIOD-1`. At `PERIOD-1` it wraps to 0 and `step` pulses the following cycle.
  - If a speed press coincides with the terminal count, that step is still emitted and the counter clears to 0.
  - If a run press (→STOP) coincides with the terminal count, the step is suppressed.
- `step` is never high for two consecutive cycles at speeds 0–2. At speed 3 with `BASE_DIV`=8, `PERIOD`=1 and `step` may be continuously high; this is legal.

## Timing
- **Key latency:** with the first edge sampling a key low as edge 1, the debounced level falls at edge `DEB_CYCLES+2` and `press` is high after edge `DEB_CYCLES+3` for exactly one cycle.
- **FSM update:** `running`/`speed` update, and a manual `step` is high, after edge `DEB_CYCLES+4`.
- **Glitch rejection:** a low glitch lasting fewer than `DEB_CYCLES` cycles at the synchronizer output produces no press.
- **Hold without repeat:** holding a key low indefinitely yields exactly one press. The next press requires a debounced release, meaning `DEB_CYCLES` stable-high cycles.
- **Auto-step timing:** after entering RUN, or after a speed change, the first auto `step` is high `PERIOD` cycles after the edge that cleared the prescaler. Thereafter it repeats every `PERIOD` cycles.
- **Reset mid-operation:** asserting `rset` during a debounce window or mid-period discards all progress. After release, behaviour is identical to power-up.

## Test plan
Bench parameters: `DEB_CYCLES`=4, `BASE_DIV`=16.
- **Reset:** hold `rset`=0 with keys low → `step`=0, `running`=0, `speed`=0. Release `rset` with keys high → no `step` for 100 cycles.
- **Debounce:** pulse `key_run` low for 3 cycles (glitch) → `running` stays 0. Hold it low for 20 cycles → exactly one press; `running`=1 after edge 8.
- **Run cadence:** in RUN at speed 0 → `step` every 16 cycles, 5 pulses in 80 cycles. Apply 3 speed presses → `speed`=3 and `step` every 2 cycles. A 4th press → `speed`=0.
- **Manual step:** in STOP, 3 separate `key_speed` presses → exactly 3 single-cycle `step` pulses; `speed` remains 0.
- **Simultaneous events:** both keys pressed on the same edge while in STOP → `running`=1, `speed`=0, no manual step.
- **Stop at terminal:** run press landing on the terminal count → no `step`; `running`=0.
- **Reset mid-operation:** assert `rset` 2 cycles into a debounce window in RUN at `speed`=2 → all outputs 0 immediately. After release, no spurious press.
